// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock; optional signed overflow via SERIAL_SUBTRACTOR_OVF_EN.
// Result valid WIDTH cycles after accept; result held in DONE until out_ready, no operand queue.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // One spare bit so the counter can step past WIDTH-1 without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic            brw;
  logic [CW-1:0]   cnt;
  logic            accept, last_bit;
  logic            d_bit, brw_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign d_bit   = a_sr[0] ^ b_sr[0] ^ brw;
  assign brw_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      brw  <= brw_nxt;
      diff <= {d_bit, diff[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      if (last_bit) bout <= brw_nxt;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // On the last bit the shift registers expose the operand sign bits directly.
  always_ff @(posedge clk) begin
    if (rst)           ovf <= 1'b0;
    else if (last_bit) ovf <= (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
